instruction_fetch: RTL and testbench

Bus initiator that fetches 32-bit instruction words from the instruction memory over the shared 256-bit system bus and hands them one at a time to the execution core via a valid/ready handshake. It drives the 16-bit address bus and nRead, waits a fixed number of cycles for the memory's registered response, captures DataBus[31:0], and advances a 12-bit program counter. It sits between the instruction memory and the core's decode stage and is the only master that addresses the instruction memory region.

---
 rtl/instruction_fetch_pkg.sv | 21 ++
 rtl/instruction_fetch.sv | 111 +++++++++++
 tb/tb_instruction_fetch.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus unit selects,
// the HALT opcode and the fetch FSM state type.
package instruction_fetch_pkg;

  // Unit selects driven on Address[15:12] of the shared system bus.
  localparam logic [3:0] InstrMemEn = 4'h1;
  localparam logic [3:0] DataMemEn  = 4'h2;
  localparam logic [3:0] IoEn       = 4'h3;
  localparam logic [3:0] TimerEn    = 4'h4;

  localparam logic [7:0] HALT_OPCODE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PRESENT,
    ST_FINISH
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Bus initiator fetching 32-bit instruction words from instruction memory
// and presenting them to the core over a valid/ready handshake.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [3:0]  MEM_SEL     = InstrMemEn,
  parameter int unsigned NUM_INSTR   = 13,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [255:0] DataBus,
  output logic [15:0]  Address,
  output logic         nRead,
  output logic [31:0]  Instr,
  output logic         InstrValid,
  input  logic         InstrReady,
  output logic [11:0]  Pc,
  output logic         Done,
  output logic         Halted
);

  localparam logic [3:0]  CNT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [11:0] LAST_PC  = 12'(NUM_INSTR - 1);

  fetch_state_e state_q;
  logic [3:0]   cnt_q;
  logic [15:0]  addr_q;
  logic         nread_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic [11:0]  pc_q;
  logic         done_q;
  logic         halted_q;

  // Only the low word of the shared bus carries instruction data.
  logic unused_bus;
  assign unused_bus = ^DataBus[255:32];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      nread_q  <= 1'b1;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      done_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            pc_q     <= '0;
            done_q   <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= ST_REQ;
          end
        end
        ST_REQ: begin
          addr_q  <= {MEM_SEL, pc_q};
          nread_q <= 1'b0;
          cnt_q   <= CNT_LOAD;
          state_q <= ST_WAIT;
        end
        // nRead stays low for WAIT_CYCLES cycles: counter runs CNT_LOAD..0.
        ST_WAIT: begin
          if (cnt_q == '0) begin
            instr_q <= DataBus[31:0];
            valid_q <= 1'b1;
            nread_q <= 1'b1;
            addr_q  <= '0;
            state_q <= ST_PRESENT;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_PRESENT: begin
          if (InstrReady) begin
            valid_q <= 1'b0;
            if (instr_q[31:24] == HALT_OPCODE) begin
              halted_q <= 1'b1;
              state_q  <= ST_FINISH;
            end else if (pc_q == LAST_PC) begin
              state_q <= ST_FINISH;
            end else begin
              pc_q    <= pc_q + 12'd1;
              state_q <= ST_REQ;
            end
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Address    = addr_q;
  assign nRead      = nread_q;
  assign Instr      = instr_q;
  assign InstrValid = valid_q;
  assign Pc         = pc_q;
  assign Done       = done_q;
  assign Halted     = halted_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: default instance plus a
// WAIT_CYCLES=4 instance, each reading a shared behavioural memory.
module tb_instruction_fetch;
  import instruction_fetch_pkg::*;

  logic Clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  logic sel = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:4095];

  // Instance A: defaults (13 words, 2 wait cycles)
  logic [31:0] md_a = '0;
  logic [255:0] bus_a;
  logic [15:0] addr_a;
  logic nread_a, valid_a, done_a, halted_a, start_a, ready_a;
  logic [31:0] instr_a;
  logic [11:0] pc_a;

  // Instance B: 6 words, 4 wait cycles
  logic [31:0] md_b = '0;
  logic [255:0] bus_b;
  logic [15:0] addr_b;
  logic nread_b, valid_b, done_b, halted_b, start_b, ready_b;
  logic [31:0] instr_b;
  logic [11:0] pc_b;

  assign bus_a   = {224'b0, md_a};
  assign bus_b   = {224'b0, md_b};
  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign ready_a = ready & ~sel;
  assign ready_b = ready & sel;

  instruction_fetch dut_a (
    .Clk(Clk), .Reset(rst), .Start(start_a), .DataBus(bus_a),
    .Address(addr_a), .nRead(nread_a), .Instr(instr_a), .InstrValid(valid_a),
    .InstrReady(ready_a), .Pc(pc_a), .Done(done_a), .Halted(halted_a)
  );

  instruction_fetch #(.NUM_INSTR(6), .WAIT_CYCLES(4)) dut_b (
    .Clk(Clk), .Reset(rst), .Start(start_b), .DataBus(bus_b),
    .Address(addr_b), .nRead(nread_b), .Instr(instr_b), .InstrValid(valid_b),
    .InstrReady(ready_b), .Pc(pc_b), .Done(done_b), .Halted(halted_b)
  );

  always #5 Clk = ~Clk;

  // Views of whichever instance is currently under test
  logic [31:0] v_instr;
  logic [15:0] v_addr;
  logic [11:0] v_pc;
  logic v_valid, v_nread, v_done, v_halted;
  assign v_instr  = sel ? instr_b  : instr_a;
  assign v_addr   = sel ? addr_b   : addr_a;
  assign v_pc     = sel ? pc_b     : pc_a;
  assign v_valid  = sel ? valid_b  : valid_a;
  assign v_nread  = sel ? nread_b  : nread_a;
  assign v_done   = sel ? done_b   : done_a;
  assign v_halted = sel ? halted_b : halted_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: samples address/strobe on the falling edge, registered data.
  always @(negedge Clk) begin
    if (!nread_a) md_a <= mem[addr_a[11:0]];
    if (!nread_b) md_b <= mem[addr_b[11:0]];
  end

  // Bus monitors: strobe width, address stability, idle address, fetch count.
  int run_a = 0, run_b = 0, fcnt_a = 0, fcnt_b = 0;
  logic [15:0] faddr_a, faddr_b;

  always @(negedge Clk) begin
    if (rst) run_a = 0;
    else if (nread_a === 1'b0) begin
      if (run_a == 0) begin
        fcnt_a++;
        faddr_a = addr_a;
        check("a_fetch_addr", {16'b0, addr_a}, {16'b0, InstrMemEn, pc_a});
      end else check("a_addr_stable", {16'b0, addr_a}, {16'b0, faddr_a});
      run_a++;
    end else begin
      if (run_a != 0) check("a_nread_width", run_a, 2);
      run_a = 0;
      check("a_idle_addr", {16'b0, addr_a}, 32'h0);
    end
  end

  always @(negedge Clk) begin
    if (rst) run_b = 0;
    else if (nread_b === 1'b0) begin
      if (run_b == 0) begin
        fcnt_b++;
        faddr_b = addr_b;
        check("b_fetch_addr", {16'b0, addr_b}, {16'b0, InstrMemEn, pc_b});
      end else check("b_addr_stable", {16'b0, addr_b}, {16'b0, faddr_b});
      run_b++;
    end else begin
      if (run_b != 0) check("b_nread_width", run_b, 4);
      run_b = 0;
      check("b_idle_addr", {16'b0, addr_b}, 32'h0);
    end
  end

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w[31:24] == HALT_OPCODE) w[31:24] = 8'h00;
    return w;
  endfunction

  // One program run; expected words come from walking memory until HALT or num.
  task automatic run(input int unsigned num, input bit stall3, input bit start_in_present);
    logic [31:0] expq[$];
    bit exp_halt;
    int fc0, cyc, d;
    exp_halt = 1'b0;
    for (int unsigned k = 0; k < num; k++) begin
      expq.push_back(mem[k]);
      if (mem[k][31:24] == 8'hFF) begin
        exp_halt = 1'b1;
        break;
      end
    end
    fc0 = sel ? fcnt_b : fcnt_a;
    start = 1'b1;
    step;
    start = 1'b0;
    check("start_clears_done", {31'b0, v_done}, 0);
    check("start_pc0", {20'b0, v_pc}, 0);
    for (int k = 0; k < expq.size(); k++) begin
      ready = 1'b0;
      cyc = 0;
      while (v_valid !== 1'b1 && cyc < 40) begin
        step;
        cyc++;
      end
      if (v_valid !== 1'b1) begin
        check("valid_timeout", {31'b0, v_valid}, 1);
        return;
      end
      check("instr", v_instr, expq[k]);
      check("pc", {20'b0, v_pc}, k);
      d = (stall3 && k == 3) ? 5 : $urandom_range(0, 2);
      if (start_in_present && k == 6 && d == 0) d = 1;
      for (int i = 0; i < d; i++) begin
        if (start_in_present && k == 6 && i == 0) start = 1'b1;
        step;
        start = 1'b0;
        check("stall_instr", v_instr, expq[k]);
        check("stall_valid", {31'b0, v_valid}, 1);
        check("stall_nread", {31'b0, v_nread}, 1);
      end
      ready = 1'b1;
      step;
      ready = 1'b0;
      check("accept_drops_valid", {31'b0, v_valid}, 0);
    end
    check("done_not_early", {31'b0, v_done}, 0);
    step;
    check("done", {31'b0, v_done}, 1);
    check("halted", {31'b0, v_halted}, {31'b0, exp_halt});
    step;
    check("done_held", {31'b0, v_done}, 1);
    check("fetch_count", (sel ? fcnt_b : fcnt_a) - fc0, expq.size());
    check("final_pc", {20'b0, v_pc}, expq.size() - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    step;
    step;
    check("rst_nread", {31'b0, nread_a}, 1);
    check("rst_addr", {16'b0, addr_a}, 0);
    check("rst_instr", instr_a, 0);
    check("rst_valid", {31'b0, valid_a}, 0);
    check("rst_pc", {20'b0, pc_a}, 0);
    check("rst_done", {31'b0, done_a}, 0);
    check("rst_halted", {31'b0, halted_a}, 0);
    rst = 1'b0;
    step;

    // Sequential words, 5-cycle stall on word 3, stray Start during PRESENT
    for (int i = 0; i < 4096; i++) mem[i] = 32'h1000_0000 + i;
    run(13, 1'b1, 1'b1);

    // Random words with HALT at word 4
    for (int i = 0; i < 16; i++) mem[i] = rand_word();
    mem[4] = 32'hFF00_0000;
    run(13, 1'b0, 1'b0);

    // Reset in the middle of fetching word 1
    for (int i = 0; i < 16; i++) mem[i] = 32'h2000_0000 + i;
    start = 1'b1;
    step;
    start = 1'b0;
    ready = 1'b1;
    cyc = 0;
    while (!(v_pc == 12'd1 && v_nread == 1'b0) && cyc < 40) begin
      step;
      cyc++;
    end
    check("reach_wait", {31'b0, v_nread}, 0);
    ready = 1'b0;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("midrst_nread", {31'b0, v_nread}, 1);
    check("midrst_addr", {16'b0, v_addr}, 0);
    check("midrst_valid", {31'b0, v_valid}, 0);
    check("midrst_pc", {20'b0, v_pc}, 0);

    // Start coincident with Reset: reset wins, stays idle
    rst = 1'b1;
    start = 1'b1;
    step;
    rst = 1'b0;
    start = 1'b0;
    step;
    step;
    check("rst_start_nread", {31'b0, v_nread}, 1);
    check("rst_start_addr", {16'b0, v_addr}, 0);

    // Restart from word 0 with random content
    for (int i = 0; i < 16; i++) mem[i] = rand_word();
    run(13, 1'b0, 1'b0);

    // Four-cycle wait instance
    sel = 1'b1;
    step;
    for (int i = 0; i < 16; i++) mem[i] = rand_word();
    run(6, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) mem[i] = rand_word();
    mem[2] = 32'hFF12_3456;
    run(6, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
